// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with registered reads, write-to-read bypass and a sweep-clear FSM.
// Optional build macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_2r1w #(
    parameter int WORD_SIZE     = 8,
    parameter int REG_NUM       = 8,
    parameter int REG_ADDR_SIZE = 3
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     rd_en,
    input  logic [REG_ADDR_SIZE-1:0] rd_addr1,
    input  logic [REG_ADDR_SIZE-1:0] rd_addr2,
    output logic [WORD_SIZE-1:0]     rd_data1,
    output logic [WORD_SIZE-1:0]     rd_data2,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [REG_ADDR_SIZE-1:0] wr_addr,
    input  logic [WORD_SIZE-1:0]     wr_data,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam logic [REG_ADDR_SIZE:0]   REG_NUM_W = (REG_ADDR_SIZE+1)'(REG_NUM);
    localparam logic [REG_ADDR_SIZE-1:0] PTR_LAST  = REG_ADDR_SIZE'(REG_NUM - 1);
`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     state_next_s;
    logic [REG_ADDR_SIZE-1:0]   ptr_r;
    logic [REG_ADDR_SIZE-1:0]   ptr_next_s;
    logic [WORD_SIZE-1:0]       mem_r [REG_NUM];
    logic [WORD_SIZE-1:0]       rd_data1_r;
    logic [WORD_SIZE-1:0]       rd_data2_r;
    logic                       rd_valid_r;
    logic                       busy_r;
    logic                       wr_drop_r;
    logic                       wr_in_range_s;
    logic                       wr_zero_s;
    logic                       wr_accept_s;
    logic                       wr_drop_next_s;
    logic [WORD_SIZE-1:0]       rd_word1_s;
    logic [WORD_SIZE-1:0]       rd_word2_s;
    logic [WORD_SIZE-1:0]       rd_next1_s;
    logic [WORD_SIZE-1:0]       rd_next2_s;

    function automatic logic addr_in_range(input logic [REG_ADDR_SIZE-1:0] addr);
        return ({1'b0, addr} < REG_NUM_W);
    endfunction

    // Mid-sweep reads return zero because the array is only partially cleared at that point.
    function automatic logic [WORD_SIZE-1:0] pick_read(
        input logic [REG_ADDR_SIZE-1:0] addr,
        input logic [WORD_SIZE-1:0]     stored,
        input logic [REG_ADDR_SIZE-1:0] waddr,
        input logic [WORD_SIZE-1:0]     wdata,
        input logic                     waccept,
        input logic                     clearing
    );
        logic [WORD_SIZE-1:0] word;
        if (clearing) begin
            word = '0;
        end else if (!addr_in_range(addr)) begin
            word = '0;
        end else if (ZERO_REG && (addr == '0)) begin
            word = '0;
        end else if (waccept && (waddr == addr)) begin
            word = wdata;
        end else begin
            word = stored;
        end
        return word;
    endfunction

    // Write qualification and drop detection
    always_comb begin
        wr_in_range_s  = addr_in_range(wr_addr);
        wr_zero_s      = ZERO_REG && (wr_addr == '0);
        wr_accept_s    = wr_en && (state_r == ST_IDLE) && wr_in_range_s && !wr_zero_s;
        wr_drop_next_s = wr_en && ((state_r == ST_CLEAR) || !wr_in_range_s);
    end

    // Array read mux plus bypass/range/clear masking for both ports
    always_comb begin
        rd_word1_s = '0;
        rd_word2_s = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            rd_word1_s = (rd_addr1 == REG_ADDR_SIZE'(i)) ? mem_r[i] : rd_word1_s;
            rd_word2_s = (rd_addr2 == REG_ADDR_SIZE'(i)) ? mem_r[i] : rd_word2_s;
        end
        rd_next1_s = pick_read(rd_addr1, rd_word1_s, wr_addr, wr_data, wr_accept_s,
                               state_r == ST_CLEAR);
        rd_next2_s = pick_read(rd_addr2, rd_word2_s, wr_addr, wr_data, wr_accept_s,
                               state_r == ST_CLEAR);
    end

    // Sweep-clear next-state and pointer logic
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            ST_IDLE: begin
                ptr_next_s = '0;
                if (clear_req) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (ptr_r == PTR_LAST) begin
                    state_next_s = ST_IDLE;
                    ptr_next_s   = '0;
                end else begin
                    state_next_s = ST_CLEAR;
                    ptr_next_s   = ptr_r + REG_ADDR_SIZE'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                ptr_next_s   = '0;
            end
        endcase
    end

    // FSM state, sweep pointer and registered status/read outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            busy_r     <= 1'b0;
            wr_drop_r  <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data1_r <= '0;
            rd_data2_r <= '0;
        end else begin
            state_r    <= state_next_s;
            ptr_r      <= ptr_next_s;
            busy_r     <= (state_next_s == ST_CLEAR);
            wr_drop_r  <= wr_drop_next_s;
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_data1_r <= rd_next1_s;
                rd_data2_r <= rd_next2_s;
            end
        end
    end

    // Storage array: the sweep zeroes one word per cycle, writes land only when idle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if ((state_r == ST_CLEAR) && (ptr_r == REG_ADDR_SIZE'(i))) begin
                    mem_r[i] <= '0;
                end else if (wr_accept_s && (wr_addr == REG_ADDR_SIZE'(i))) begin
                    mem_r[i] <= wr_data;
                end
            end
        end
    end

    assign rd_data1 = rd_data1_r;
    assign rd_data2 = rd_data2_r;
    assign rd_valid = rd_valid_r;
    assign busy     = busy_r;
    assign wr_drop  = wr_drop_r;

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised successor to the CPU core general-purpose register file: 2 read ports, 1 write port, configurable WORD_SIZE and REG_NUM.
- Adds registered reads with a valid strobe, same-cycle write-to-read bypass, out-of-range address handling, and a multi-cycle sweep-clear FSM with a busy handshake.
- Sits between instruction decode (reads and writes) and the ALU/writeback stage.

Parameters:
- WORD_SIZE, 8, data width of each register in bits.
- REG_NUM, 8, number of registers. Legal range is 2..2^REG_ADDR_SIZE.
- REG_ADDR_SIZE, 3, address width in bits.

Ports:
- clock  input  1  single clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- rd_en  input  1  read request, sampled at posedge.
- rd_addr1  input  REG_ADDR_SIZE  read port 1 address.
- rd_addr2  input  REG_ADDR_SIZE  read port 2 address.
- rd_data1  output  WORD_SIZE  registered read data, port 1.
- rd_data2  output  WORD_SIZE  registered read data, port 2.
- rd_valid  output  1  1-cycle pulse: rd_data1/rd_data2 were updated this cycle.
- wr_en  input  1  write request.
- wr_addr  input  REG_ADDR_SIZE  write address.
- wr_data  input  WORD_SIZE  write data.
- clear_req  input  1  request a sweep-clear of all registers.
- busy  output  1  high while the sweep-clear is in progress.
- wr_drop  output  1  1-cycle pulse: the previous cycle's write was discarded.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All registers are set to 0.
  - rd_data1, rd_data2, rd_valid, busy and wr_drop are 0.
  - FSM is IDLE; clear pointer is 0.
  - Reset asserted mid-clear aborts the sweep immediately.
- Read:
  - Latency is 1 cycle. When rd_en=1 at edge N, rd_data1/rd_data2 and rd_valid=1 are visible after edge N.
  - When rd_en=0, rd_data1/rd_data2 hold their previous values and rd_valid=0.
- Bypass: if wr_en=1 and the write is accepted at the same edge, any read port whose address equals wr_addr returns wr_data, not the old contents.
- Out-of-range address (addr >= REG_NUM):
  - A read on that port returns 0.
  - The write is discarded and wr_drop pulses.
- Write: accepted when wr_en=1, the FSM is IDLE and wr_addr is in range. The register updates at that edge and is readable by the next read.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR: on clear_req=1. busy goes to 1 after that edge. Pointer starts at 0.
  - CLEAR: zeroes register[ptr] each cycle and increments ptr. After ptr=REG_NUM-1 is cleared, the FSM returns to IDLE and busy drops.
  - busy stays high for exactly REG_NUM cycles.
  - clear_req while busy is ignored; no restart.
  - wr_en during CLEAR: the write is discarded and wr_drop pulses on the following cycle.
  - rd_en during CLEAR: reads are honoured, rd_valid=1, and the returned data is 0.
- Simultaneous clear_req and an accepted write in IDLE: the write lands at that edge and is then zeroed by the sweep. wr_drop=0.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to 0.
  - Reads of address 0 always return 0, including under bypass.
  - Writes to address 0 are silently ignored; wr_drop is not asserted.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then read: release reset_n, rd_en with addr1=3, addr2=7 -> after the next edge rd_data1=0, rd_data2=0, rd_valid=1.
- Write then read: wr_en, addr 5, data 0xA5 -> next cycle rd_en with addr1=5 -> rd_data1=0xA5 one cycle later.
- Bypass: reg 2 holds 0x11; same cycle wr_en addr 2, data 0x3C plus rd_en addr1=2, addr2=2 -> both ports return 0x3C, rd_valid=1.
- Sweep-clear: fill regs 0..7 with 0xFF, pulse clear_req -> busy high exactly 8 cycles. A wr_en addr 4 during busy -> wr_drop pulses. After busy falls, reads of every register return 0.
- Reset mid-clear: assert reset_n=0 on the 3rd busy cycle -> busy=0 immediately, all registers 0, FSM IDLE. A subsequent write/read of 0x42 works normally.
- Out-of-range and optional feature:
  - REG_NUM=6: write to addr 6 -> wr_drop=1, contents unchanged; read of addr 7 -> 0.
  - With REGFILE_ZERO_REG_EN: write 0x55 to addr 0 -> read of addr 0 returns 0, wr_drop=0.
